// File: rtl/demux_deser_8.sv
`default_nettype none
// ============================================================================
// Module      : demux_deser_8
// Description : Serial-to-parallel lane deserializer. Drives the transmit
//               mux select and rebuilds the 2**SEL_W-bit word one bit at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_deser_8 #(
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    sof,
  output logic [SEL_W-1:0]        S,
  output logic [(2**SEL_W)-1:0]   dout,
  output logic                    dout_valid,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int              c_LANES     = 2**SEL_W;
  localparam logic [SEL_W-1:0] c_LAST_LANE = SEL_W'(c_LANES - 1);
  localparam logic [SEL_W-1:0] c_LANE_ONE  = SEL_W'(1);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;

  logic [0:0]           r_state;
  logic [SEL_W-1:0]     r_cnt;
  logic [c_LANES-1:0]   r_shadow;
  logic [c_LANES-1:0]   r_dout;
  logic                 r_dout_valid;
  logic                 r_frame_err;

  // Shadow with the current bit merged in; on the last lane this is the full word.
  logic [c_LANES-1:0]   w_shadow_ins;

  always_comb begin
    w_shadow_ins        = r_shadow;
    w_shadow_ins[r_cnt] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (din_valid) begin
        case (r_state)
          c_ST_IDLE: begin
            if (sof) begin
              r_shadow[0] <= din;
              r_cnt       <= c_LANE_ONE;
              r_state     <= c_ST_SHIFT;
            end
          end
          c_ST_SHIFT: begin
            if (sof) begin
              // Restart: the partial frame is dropped, this bit becomes lane 0.
              r_frame_err <= 1'b1;
              r_shadow[0] <= din;
              r_cnt       <= c_LANE_ONE;
            end else begin
              r_shadow <= w_shadow_ins;
              if (r_cnt == c_LAST_LANE) begin
                r_dout       <= w_shadow_ins;
                r_dout_valid <= 1'b1;
                r_cnt        <= '0;
                r_state      <= c_ST_IDLE;
              end else begin
                r_cnt <= r_cnt + c_LANE_ONE;
              end
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign S          = r_cnt;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == c_ST_SHIFT);

endmodule
`default_nettype wire
